// File: rtl/az_sequencer.sv
// az_sequencer: charge / auto-zero / hold measurement sequencer.
// Walks IDLE -> CHARGE -> AZ -> HOLD -> DONE -> IDLE. Each timed phase lasts
// its latched length in clk cycles, and a length of 0 is treated as 1.
// Every output is registered and reflects the current state with no extra latency.
//
// Optional feature: define AZ_SEQ_REPEAT_EN to add the repeat_seq input.
// When repeat_seq is high in DONE, the sequence restarts in CHARGE using the
// same latched configuration. (`repeat` is a reserved word, so the port is repeat_seq.)
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   start            level-sampled start request, taken only in IDLE
//   abort            return to IDLE on the next edge from any state
//   t_charge_n/t_az_n/t_hold_n  phase lengths in cycles (CNT_W bits)
//   hi_sel           himux code for CHARGE: [2:0]=HI1 switch, [5:3]=HI2 switch
//   repeat_seq       (AZ_SEQ_REPEAT_EN only) chain another sequence from DONE
//   mux_hi, mode     registered himux drive and AZ modulator mode
//   busy, done       busy from CHARGE through DONE; one-cycle done pulse
//   phase            state code: 0=IDLE 1=CHARGE 2=AZ 3=HOLD 4=DONE
//   cycle_count      completed sequences, wraps modulo 2^CYC_W
module az_sequencer #(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned CYC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef AZ_SEQ_REPEAT_EN
    input  logic             repeat_seq,
`endif
    input  logic [CNT_W-1:0] t_charge_n,
    input  logic [CNT_W-1:0] t_az_n,
    input  logic [CNT_W-1:0] t_hold_n,
    input  logic [5:0]       hi_sel,
    output logic [5:0]       mux_hi,
    output logic [6:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_AZ     = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [5:0] MUX_IDLE   = 6'd20;  // HI1=4 NC, HI2=2 NC
    localparam logic [2:0] HI1_OPEN   = 3'd4;
    localparam logic [6:0] MODE_AZ    = 7'd1;
    localparam logic [6:0] MODE_SIGHI = 7'd2;
    localparam logic [6:0] MODE_LO    = 7'd3;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] lat_tc, lat_tc_n, lat_ta, lat_ta_n, lat_th, lat_th_n;
    logic [5:0]       lat_hi, lat_hi_n;
    logic [CYC_W-1:0] cyc_n;
    logic [5:0]       mux_hi_n;
    logic [6:0]       mode_n;
    logic             busy_n, done_n;

    // Cycles remaining after the current one; a zero length behaves as one.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    // Next state, counter, latched configuration and next outputs.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lat_tc_n = lat_tc;
        lat_ta_n = lat_ta;
        lat_th_n = lat_th;
        lat_hi_n = lat_hi;
        cyc_n    = cycle_count;
        mux_hi_n = MUX_IDLE;
        mode_n   = MODE_LO;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_CHARGE;
                    lat_tc_n = t_charge_n;
                    lat_ta_n = t_az_n;
                    lat_th_n = t_hold_n;
                    lat_hi_n = hi_sel;
                    cnt_n    = len_m1(t_charge_n);
                end
            end
            S_CHARGE: begin
                if (cnt == '0) begin
                    state_n = S_AZ;
                    cnt_n   = len_m1(lat_ta);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_AZ: begin
                if (cnt == '0) begin
                    state_n = S_HOLD;
                    cnt_n   = len_m1(lat_th);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_n = S_DONE;
                    cyc_n   = cycle_count + CYC_W'(1);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
`ifdef AZ_SEQ_REPEAT_EN
                if (repeat_seq) begin
                    state_n = S_CHARGE;
                    cnt_n   = len_m1(lat_tc);
                end else begin
                    state_n = S_IDLE;
                end
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase

        // Abort wins over everything, including start in IDLE and the count bump.
        if (abort) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            lat_tc_n = lat_tc;
            lat_ta_n = lat_ta;
            lat_th_n = lat_th;
            lat_hi_n = lat_hi;
            cyc_n    = cycle_count;
        end

        // Decode the outputs from the next state so they register with it.
        case (state_n)
            S_CHARGE: begin
                mux_hi_n = lat_hi_n;
                mode_n   = MODE_SIGHI;
            end
            S_AZ: begin
                mux_hi_n = {lat_hi_n[5:3], HI1_OPEN};
                mode_n   = MODE_AZ;
            end
            S_HOLD, S_DONE: begin
                mux_hi_n = {lat_hi_n[5:3], HI1_OPEN};
                mode_n   = MODE_SIGHI;
            end
            default: begin
                mux_hi_n = MUX_IDLE;
                mode_n   = MODE_LO;
            end
        endcase
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_tc      <= '0;
            lat_ta      <= '0;
            lat_th      <= '0;
            lat_hi      <= '0;
            cycle_count <= '0;
            mux_hi      <= MUX_IDLE;
            mode        <= MODE_LO;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lat_tc      <= lat_tc_n;
            lat_ta      <= lat_ta_n;
            lat_th      <= lat_th_n;
            lat_hi      <= lat_hi_n;
            cycle_count <= cyc_n;
            mux_hi      <= mux_hi_n;
            mode        <= mode_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    assign phase = state;

endmodule

// File: doc/az_sequencer.md
AZ_SEQUENCER -- requirements
Module: az_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of the phase-duration inputs and of the phase counter.
REQ-002 SHALL have parameter CYC_W, default 16, width of cycle_count.
REQ-003 SHALL have port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level-sampled request to begin one charge/AZ/hold sequence.
REQ-006 SHALL have port abort  input  1  terminate any sequence and return to IDLE.
REQ-007 SHALL have port t_charge_n  input  CNT_W  CHARGE phase length in clk cycles.
REQ-008 SHALL have port t_az_n  input  CNT_W  AZ phase length in clk cycles.
REQ-009 SHALL have port t_hold_n  input  CNT_W  HOLD phase length in clk cycles.
REQ-010 SHALL have port hi_sel  input  6  himux code applied during CHARGE; [2:0]=HI1 switch, [5:3]=HI2 switch.
REQ-011 SHALL have port mux_hi  output  6  registered himux drive.
REQ-012 SHALL have port mode  output  7  registered AZ modulator mode; 1=AZ_NORMAL, 2=SIGNAL_HI, 3=LO.
REQ-013 SHALL have port busy  output  1  high from CHARGE entry through DONE inclusive.
REQ-014 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-015 SHALL have port phase  output  3  current state encoding: 0=IDLE, 1=CHARGE, 2=AZ, 3=HOLD, 4=DONE.
REQ-016 SHALL have port cycle_count  output  CYC_W  count of completed sequences.

Function
REQ-017 SHALL implement the state machine IDLE -> CHARGE -> AZ -> HOLD -> DONE -> IDLE.
REQ-018 SHALL, in IDLE, drive mux_hi=6'd20 (HI1=4 NC, HI2=2 NC), mode=3, busy=0.
REQ-019 SHALL, when start=1 in IDLE, latch t_charge_n, t_az_n, t_hold_n and hi_sel, and enter CHARGE on the next edge.
REQ-020 SHALL, in CHARGE, drive mux_hi=latched hi_sel and mode=2.
REQ-021 SHALL, in AZ and HOLD, drive mux_hi={latched hi_sel[5:3],3'd4} (HI1 opened); mode=1 in AZ, 2 in HOLD.
REQ-022 SHALL hold each of CHARGE, AZ and HOLD for exactly its latched length in cycles; a length of 0 SHALL be treated as 1.
REQ-023 SHALL, in DONE, hold the HOLD-phase outputs, assert done for exactly that one cycle, and increment cycle_count, wrapping modulo 2^CYC_W.
REQ-024 SHALL make busy high for exactly Tc+Ta+Th+1 cycles per completed sequence.
REQ-025 SHALL ignore start while busy=1, and SHALL leave latched configuration unaffected by input changes during a sequence.
REQ-026 SHALL, when abort=1 in any state, enter IDLE on the next edge with IDLE outputs, no done pulse, and cycle_count unchanged.
REQ-027 SHALL give abort priority over start when both are asserted in IDLE, remaining in IDLE.
REQ-028 SHALL register all outputs; output values SHALL correspond to the current state with no additional latency.

Reset
REQ-029 SHALL, on reset=1, immediately force state=IDLE, mux_hi=6'd20, mode=3, busy=0, done=0, phase=0, cycle_count=0, and clear the counter and latched configuration.
REQ-030 SHALL, when reset asserts mid-sequence, suppress done, and SHALL resume operation in IDLE on the first edge after reset deasserts.

Configuration
REQ-031 SHALL, with macro AZ_SEQ_REPEAT_EN defined, add input port repeat (1 bit); when repeat=1 in DONE, the next state SHALL be CHARGE using the previously latched configuration, with busy held high and done still pulsing.
REQ-032 SHALL, without AZ_SEQ_REPEAT_EN, have no repeat port, and DONE SHALL always return to IDLE.

Verification
REQ-033 SHALL test Tc=3, Ta=5, Th=2, with start pulsed at cycle 0 -> mode=2 at cycles 1-3, mode=1 at 4-8, mode=2 at 9-10, done=1 at 11 only, busy=0 at 12, cycle_count=1.
REQ-034 SHALL test hi_sel=6'b010_110 in CHARGE -> mux_hi=6'b010_110; in AZ -> mux_hi=6'b010_100; in IDLE -> mux_hi=6'd20.
REQ-035 SHALL test abort asserted at cycle 5 of the REQ-033 run -> phase=0 and mode=3 at cycle 6, no done pulse, cycle_count unchanged.
REQ-036 SHALL test t_charge_n=0, t_az_n=0, t_hold_n=0 -> each phase lasts 1 cycle, done at cycle 4; start re-pulsed at cycle 2 is ignored.
REQ-037 SHALL test cycle_count preset to 16'hFFFF by running 65535 sequences, then one more sequence -> cycle_count=0.
REQ-038 SHALL test, with AZ_SEQ_REPEAT_EN and repeat=1 under the REQ-033 settings -> done at cycles 11 and 22, CHARGE re-entered at cycle 12, busy continuously high.
